gyro_cmd_ctrl: RTL and testbench



---
 rtl/gyro_pkg.sv | 37 +++
 rtl/gyro_cmd_ctrl_edge_det.sv | 24 ++
 rtl/gyro_cmd_ctrl.sv | 121 ++++++++++++
 tb/tb_gyro_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro torque-command sequencer: FSM states,
// channel 14 field positions and axis select codes.
package gyro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_WACK  = 2'd3
  } gyro_state_e;

  // Positions within the 5-bit channel 14 field (channel bits 6..10)
  localparam int CH_PWR  = 0;
  localparam int CH_SIGN = 1;
  localparam int CH_SELA = 2;
  localparam int CH_SELB = 3;
  localparam int CH_ACT  = 4;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_X    = 2'b01;
  localparam logic [1:0] SEL_Y    = 2'b10;
  localparam logic [1:0] SEL_Z    = 2'b11;

  // Torque pulse vector ordered {XP, XM, YP, YM, ZP, ZM}
  function automatic logic [5:0] torque_vec(input logic [1:0] sel, input logic minus);
    logic [5:0] v;
    v = 6'b000000;
    case (sel)
      SEL_X:   v = minus ? 6'b010000 : 6'b100000;
      SEL_Y:   v = minus ? 6'b000100 : 6'b001000;
      SEL_Z:   v = minus ? 6'b000001 : 6'b000010;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gyro_cmd_ctrl_edge_det.sv
// Registered single-polarity edge detector: the strobe is high for one
// clock, in the cycle after the input change is first sampled.
module edge_det #(
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_q
);

  logic d_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_p0   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      d_p0   <= d;
      edge_q <= FALL_EDGE ? (~d & d_p0) : (d & ~d_p0);
    end
  end

endmodule

// File: rtl/gyro_cmd_ctrl.sv
// Gyro torque-command sequencer: channel 14 register, window/tone driven
// torque pulses and the GYROD decrement handshake.
module gyro_cmd_ctrl
  import gyro_pkg::*;
(
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic GOJAM,
  input  logic WCH14_n,
  input  logic CCH14,
  input  logic CHWL06_n,
  input  logic CHWL07_n,
  input  logic CHWL08_n,
  input  logic CHWL09_n,
  input  logic CHWL10_n,
  input  logic GTSET,
  input  logic GTRST_n,
  input  logic GTONE,
  input  logic GYROD_ACK,
  input  logic GYRZRO,
  output logic CH1406,
  output logic CH1407,
  output logic CH1408,
  output logic CH1409,
  output logic CH1410,
  output logic GYENAB,
  output logic GYXP,
  output logic GYXM,
  output logic GYYP,
  output logic GYYM,
  output logic GYZP,
  output logic GYZM,
  output logic GYROD_REQ,
  output logic GYOVF
);

  logic        rst;
  logic        set_rise;
  logic        tone_rise;
  logic        win_fall;
  gyro_state_e state;
  logic [4:0]  ch14;
  logic [4:0]  wr_bits;
  logic [1:0]  sel;
  logic        active;
  logic        zero_ack;
  logic [5:0]  pulse_q;
  logic        req_q;
  logic        ovf_q;

  assign rst = SIM_RST | GOJAM;

  edge_det #(.FALL_EDGE(1'b0)) u_set_det  (.clk(SIM_CLK), .rst(rst), .d(GTSET),   .edge_q(set_rise));
  edge_det #(.FALL_EDGE(1'b0)) u_tone_det (.clk(SIM_CLK), .rst(rst), .d(GTONE),   .edge_q(tone_rise));
  edge_det #(.FALL_EDGE(1'b1)) u_win_det  (.clk(SIM_CLK), .rst(rst), .d(GTRST_n), .edge_q(win_fall));

  assign wr_bits  = ~{CHWL10_n, CHWL09_n, CHWL08_n, CHWL07_n, CHWL06_n};
  assign sel      = {ch14[CH_SELB], ch14[CH_SELA]};
  assign active   = ch14[CH_ACT] && (sel != SEL_NONE);
  assign zero_ack = (state == ST_WACK) && GYROD_ACK && GYRZRO;

  always_ff @(posedge SIM_CLK) begin
    if (rst) begin
      state   <= ST_IDLE;
      ch14    <= 5'b00000;
      pulse_q <= 6'b000000;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pulse_q <= 6'b000000;
      case (state)
        ST_IDLE: begin
          if (active) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!active)       state <= ST_IDLE;
          else if (set_rise) state <= ST_RUN;
        end
        ST_RUN: begin
          if (win_fall)     state <= ST_ARMED;
          else if (!active) state <= ST_IDLE;
          else if (tone_rise) begin
            pulse_q <= torque_vec(sel, ch14[CH_SIGN]);
            req_q   <= 1'b1;
            state   <= ST_WACK;
          end
        end
        ST_WACK: begin
          if (GYROD_ACK) begin
            req_q <= 1'b0;
            state <= GYRZRO ? ST_IDLE : ST_RUN;
          end else if (tone_rise) begin
            ovf_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Register update ordering gives clear > write > zero-ack bit10 clear
      if (CCH14) begin
        ch14  <= 5'b00000;
        ovf_q <= 1'b0;
      end else if (!WCH14_n) begin
        ch14 <= wr_bits;
      end else if (zero_ack) begin
        ch14[CH_ACT] <= 1'b0;
      end
    end
  end

  assign CH1406 = ch14[CH_PWR];
  assign CH1407 = ch14[CH_SIGN];
  assign CH1408 = ch14[CH_SELA];
  assign CH1409 = ch14[CH_SELB];
  assign CH1410 = ch14[CH_ACT];
  assign GYENAB = ch14[CH_PWR];
  assign {GYXP, GYXM, GYYP, GYYM, GYZP, GYZM} = pulse_q;
  assign GYROD_REQ = req_q;
  assign GYOVF     = ovf_q;

endmodule

// File: tb/tb_gyro_cmd_ctrl.sv
// Directed testbench for gyro_cmd_ctrl with hand-computed expectations.
module tb_gyro_cmd_ctrl;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic GOJAM = 1'b0;
  logic WCH14_n = 1'b1;
  logic CCH14 = 1'b0;
  logic [4:0] chwl_n = 5'b11111;
  logic GTSET = 1'b0;
  logic GTRST_n = 1'b1;
  logic GTONE = 1'b0;
  logic GYROD_ACK = 1'b0;
  logic GYRZRO = 1'b0;
  logic CH1406, CH1407, CH1408, CH1409, CH1410, GYENAB;
  logic GYXP, GYXM, GYYP, GYYM, GYZP, GYZM, GYROD_REQ, GYOVF;

  int errors = 0;
  int checks = 0;
  int cnt_xp = 0;
  int cnt_zm = 0;
  int cnt_all = 0;

  wire [4:0]  ch_rb = {CH1410, CH1409, CH1408, CH1407, CH1406};
  wire [5:0]  pv    = {GYXP, GYXM, GYYP, GYYM, GYZP, GYZM};
  wire [14:0] all_o = {ch_rb, GYENAB, pv, GYROD_REQ, GYOVF};

  always #5 SIM_CLK = ~SIM_CLK;

  gyro_cmd_ctrl dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .GOJAM(GOJAM),
    .WCH14_n(WCH14_n), .CCH14(CCH14),
    .CHWL06_n(chwl_n[0]), .CHWL07_n(chwl_n[1]), .CHWL08_n(chwl_n[2]),
    .CHWL09_n(chwl_n[3]), .CHWL10_n(chwl_n[4]),
    .GTSET(GTSET), .GTRST_n(GTRST_n), .GTONE(GTONE),
    .GYROD_ACK(GYROD_ACK), .GYRZRO(GYRZRO),
    .CH1406(CH1406), .CH1407(CH1407), .CH1408(CH1408), .CH1409(CH1409),
    .CH1410(CH1410), .GYENAB(GYENAB),
    .GYXP(GYXP), .GYXM(GYXM), .GYYP(GYYP), .GYYM(GYYM), .GYZP(GYZP), .GYZM(GYZM),
    .GYROD_REQ(GYROD_REQ), .GYOVF(GYOVF)
  );

  always @(negedge SIM_CLK) begin
    if (GYXP) cnt_xp++;
    if (GYZM) cnt_zm++;
    cnt_all += int'(GYXP) + int'(GYXM) + int'(GYYP) + int'(GYYM) + int'(GYZP) + int'(GYZM);
  end

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic do_reset();
    SIM_RST = 1'b1;
    tick();
    tick();
    SIM_RST = 1'b0;
  endtask

  task automatic wr14(input logic [4:0] bits);
    chwl_n  = ~bits;
    WCH14_n = 1'b0;
    tick();
    WCH14_n = 1'b1;
    chwl_n  = 5'b11111;
  endtask

  task automatic gtset_edge();
    GTSET = 1'b1;
    tick();
    GTSET = 1'b0;
    tick();
  endtask

  task automatic gtone_edge();
    GTONE = 1'b1;
    tick();
    GTONE = 1'b0;
    tick();
  endtask

  task automatic gtrst_edge();
    GTRST_n = 1'b0;
    tick();
    GTRST_n = 1'b1;
    tick();
  endtask

  task automatic ack(input logic zro);
    GYROD_ACK = 1'b1;
    GYRZRO    = zro;
    tick();
    GYROD_ACK = 1'b0;
    GYRZRO    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_o !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", all_o, 15'd0);
    end
  endtask

  task automatic test_plus_x();
    int xp0;
    do_reset();
    xp0 = cnt_xp;
    wr14(5'b10101);
    checks++;
    if (ch_rb !== 5'b10101) begin errors++; $display("FAIL px_readback: got %b want %b", ch_rb, 5'b10101); end
    checks++;
    if (GYENAB !== 1'b1) begin errors++; $display("FAIL px_gyenab: got %b want 1", GYENAB); end
    tick();
    gtset_edge();
    gtone_edge();
    checks++;
    if (pv !== 6'b100000) begin errors++; $display("FAIL px_pulse1: got %b want %b", pv, 6'b100000); end
    checks++;
    if (GYROD_REQ !== 1'b1) begin errors++; $display("FAIL px_req_rise: got %b want 1", GYROD_REQ); end
    tick();
    checks++;
    if (pv !== 6'b000000) begin errors++; $display("FAIL px_pulse_width: got %b want %b", pv, 6'b000000); end
    checks++;
    if (GYROD_REQ !== 1'b1) begin errors++; $display("FAIL px_req_hold: got %b want 1", GYROD_REQ); end
    ack(1'b0);
    checks++;
    if (GYROD_REQ !== 1'b0) begin errors++; $display("FAIL px_req_drop: got %b want 0", GYROD_REQ); end
    gtone_edge();
    checks++;
    if (pv !== 6'b100000) begin errors++; $display("FAIL px_pulse2: got %b want %b", pv, 6'b100000); end
    tick();
    checks++;
    if (cnt_xp - xp0 !== 2) begin errors++; $display("FAIL px_count: got %0d want 2", cnt_xp - xp0); end
  endtask

  task automatic test_zminus_zero();
    int zm0;
    int all0;
    ack(1'b0);
    wr14(5'b11111);
    zm0  = cnt_zm;
    all0 = cnt_all;
    gtone_edge();
    checks++;
    if (pv !== 6'b000001) begin errors++; $display("FAIL zm_pulse: got %b want %b", pv, 6'b000001); end
    tick();
    ack(1'b1);
    checks++;
    if (GYROD_REQ !== 1'b0) begin errors++; $display("FAIL zm_req_drop: got %b want 0", GYROD_REQ); end
    checks++;
    if (ch_rb !== 5'b01111) begin errors++; $display("FAIL zm_bit10_clear: got %b want %b", ch_rb, 5'b01111); end
    gtone_edge();
    gtset_edge();
    gtone_edge();
    tick();
    checks++;
    if (cnt_zm - zm0 !== 1) begin errors++; $display("FAIL zm_count: got %0d want 1", cnt_zm - zm0); end
    checks++;
    if (cnt_all - all0 !== 1) begin errors++; $display("FAIL zm_total_pulses: got %0d want 1", cnt_all - all0); end
  endtask

  task automatic test_overflow();
    int all0;
    do_reset();
    wr14(5'b10101);
    tick();
    gtset_edge();
    all0 = cnt_all;
    gtone_edge();
    tick();
    gtone_edge();
    checks++;
    if (GYOVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", GYOVF); end
    checks++;
    if (pv !== 6'b000000) begin errors++; $display("FAIL ovf_no_pulse: got %b want %b", pv, 6'b000000); end
    checks++;
    if (GYROD_REQ !== 1'b1) begin errors++; $display("FAIL ovf_req_held: got %b want 1", GYROD_REQ); end
    tick();
    checks++;
    if (cnt_all - all0 !== 1) begin errors++; $display("FAIL ovf_pulse_count: got %0d want 1", cnt_all - all0); end
    CCH14 = 1'b1;
    tick();
    CCH14 = 1'b0;
    checks++;
    if (GYOVF !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", GYOVF); end
    checks++;
    if ({ch_rb, GYENAB} !== 6'b000000) begin errors++; $display("FAIL cch14_clear: got %b want %b", {ch_rb, GYENAB}, 6'b000000); end
  endtask

  task automatic test_window_reset();
    do_reset();
    wr14(5'b10101);
    tick();
    gtset_edge();
    gtrst_edge();
    gtone_edge();
    checks++;
    if ({pv, GYROD_REQ} !== 7'b0000000) begin errors++; $display("FAIL gtrst_tone_ignored: got %b want %b", {pv, GYROD_REQ}, 7'b0000000); end
    gtset_edge();
    gtone_edge();
    checks++;
    if ({pv, GYROD_REQ} !== 7'b1000001) begin errors++; $display("FAIL gtrst_rearm_pulse: got %b want %b", {pv, GYROD_REQ}, 7'b1000001); end
  endtask

  task automatic test_gojam();
    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    checks++;
    if (all_o !== 15'd0) begin errors++; $display("FAIL gojam_outputs: got %b want %b", all_o, 15'd0); end
    gtset_edge();
    gtone_edge();
    checks++;
    if ({pv, GYROD_REQ} !== 7'b0000000) begin errors++; $display("FAIL gojam_idle: got %b want %b", {pv, GYROD_REQ}, 7'b0000000); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr14(5'b10101);
    tick();
    gtset_edge();
    gtone_edge();
    chwl_n    = ~5'b10101;
    WCH14_n   = 1'b0;
    GYROD_ACK = 1'b1;
    GYRZRO    = 1'b1;
    tick();
    WCH14_n   = 1'b1;
    GYROD_ACK = 1'b0;
    GYRZRO    = 1'b0;
    checks++;
    if (CH1410 !== 1'b1) begin errors++; $display("FAIL write_beats_zero_ack: got %b want 1", CH1410); end
    checks++;
    if (GYROD_REQ !== 1'b0) begin errors++; $display("FAIL zero_ack_req_drop: got %b want 0", GYROD_REQ); end
    chwl_n  = ~5'b11111;
    WCH14_n = 1'b0;
    CCH14   = 1'b1;
    tick();
    WCH14_n = 1'b1;
    CCH14   = 1'b0;
    chwl_n  = 5'b11111;
    checks++;
    if (ch_rb !== 5'b00000) begin errors++; $display("FAIL clear_beats_write: got %b want %b", ch_rb, 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_plus_x();
    test_zminus_zero();
    test_overflow();
    test_window_reset();
    test_gojam();
    test_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
